arm_trace_capture: RTL and testbench
====================================

# arm_trace_capture

Execution-trace capture stage for the single-cycle ARM core. It sits directly downstream of the `arm` top level and samples the core's debug outputs (`Instr`, `PC_out`, `ALUResult`, `ALUControl`) every enabled cycle into a circular buffer. It detects the halt instruction and stops capturing when it sees it. The buffer is drained through a valid/ready read port, so a bench or debug host can retrieve an ordered trace without printing every clock edge.

## Interface
- `DEPTH`, 16: number of trace entries; must be a power of two, ≥2.
- `CNT_W`, 16: width of the statistics counters.
- `HALT_INSTR`, 32'hE000_0000: instruction word that ends capture.

- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `Instr` in 32: instruction executing this cycle, from the core.
- `PC_out` in 32: PC of that instruction.
- `ALUResult` in 32: ALU result this cycle.
- `ALUControl` in 2: ALU operation select this cycle.
- `cap_en` in 1: the core's outputs are valid this cycle; sample them.
- `rd_valid` out 1: the head entry is available.
- `rd_ready` in 1: the consumer accepts the head entry.
- `rd_instr`, `rd_pc`, `rd_alu` out 32 each: head entry fields.
- `rd_aluctl` out 2: head entry ALU control.
- `halted` out 1: the halt instruction has been seen.
- `done` out 1: halted and the buffer is fully drained.
- `overflow` out 1: sticky; at least one entry was dropped.
- `drop_count` out CNT_W: number of dropped entries; saturates at all-ones.
- `cycle_count` out CNT_W: number of enabled capture cycles, including the halt cycle; saturates.

## Operation
- States:
  - CAPTURE: the reset state.
  - DRAIN: captures are frozen; reads continue.
  - DONE: captures are frozen and the buffer is empty.
- Transitions:
  - CAPTURE→DRAIN on the edge where `cap_en`=1 and `Instr`==HALT_INSTR.
  - DRAIN→DONE on the edge where the post-edge occupancy is 0. If the buffer is already empty when halt is seen, the block goes DRAIN→DONE on the next edge.
  - DONE is terminal until `RST`.
- Write, in CAPTURE only, with `cap_en`=1 and `Instr`≠HALT_INSTR:
  - Push {Instr, PC_out, ALUResult, ALUControl} at the tail.
  - The halt instruction itself is never written.
- Full policy: drop the newest sample.
  - `overflow`←1 and `drop_count` increments.
  - Exception: if a pop happens on the same edge, the slot is freed and the write succeeds with no drop.
- Read: show-ahead.
  - `rd_valid` = occupancy≠0.
  - `rd_*` show the head entry whenever `rd_valid`=1; their value is don't-care otherwise.
  - A pop occurs when `rd_valid`&&`rd_ready`. Reads are legal in all states.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits.
- `cycle_count` increments in CAPTURE whenever `cap_en`=1.
- Inputs are ignored in DRAIN and DONE, including further halt words.
- `halted` = state≠CAPTURE. `done` = state==DONE.

## Timing
- Reset:
  - Pointers, occupancy, `overflow`, `drop_count`, and `cycle_count` go to 0. State goes to CAPTURE.
  - Consequently `rd_valid`, `halted`, and `done` are 0. The `rd_*` data outputs are don't-care while `rd_valid`=0.
  - Reset applied at any point, including mid-drain, discards all contents.
- Write latency is 1: a sample taken at edge N makes `rd_valid` high after edge N, provided the buffer was empty.
- Pop: after the pop edge, `rd_*` present the next entry in the same cycle, or `rd_valid` drops.
- `halted` rises the cycle after the halt edge.
- `done` rises the cycle after the edge that pops the last entry.
- No combinational path from `Instr`/`cap_en` to `rd_*` or `rd_valid`. `rd_*` are combinational only from registered storage and pointers.

## Structure
- Shared package `arm_trace_pkg`:
  - `HALT_INSTR` default constant.
  - State enum {CAPTURE, DRAIN, DONE}.
  - `trace_entry_t` struct {instr[31:0], pc[31:0], alu[31:0], aluctl[1:0]}, 98 bits.
- Sub-module `trace_fifo`: a synchronous show-ahead FIFO of `trace_entry_t`, DEPTH entries. It provides push, pop, full, empty, and push-while-full-with-pop behaviour.
- The top level holds the state machine, drop policy, and saturating counters.

## Test plan
1. **Basic capture and halt.** Reset, then 3 enabled instructions (PC 0, 4, 8), then HALT_INSTR, with `rd_ready`=0.
   - Required: `halted`=1 the next cycle, `cycle_count`=4, and 3 entries read back in PC order with matching fields.
2. **Overflow.** DEPTH=16, 20 enabled non-halt instructions, no reads.
   - Required: `overflow`=1, `drop_count`=4, and the retained entries are exactly the first 16.
3. **Full with simultaneous pop and push.** With the buffer full, hold `rd_ready`=1 while a new enabled instruction arrives.
   - Required: the write is accepted, occupancy stays at 16, `drop_count` is unchanged, and the order is preserved.
4. **Drain.** After halt, pulse `rd_ready` until empty, while feeding further non-halt and halt words.
   - Required: those words are never captured, and `done`=1 the cycle after the last pop.
5. **Reset mid-drain.** Assert `RST` for 1 cycle in DRAIN with 5 entries held.
   - Required: `rd_valid`, `halted`, `done`, and `overflow` are 0, the counts are 0, and capture restarts.
6. **Enable gating.** HALT_INSTR and other words presented with `cap_en`=0.
   - Required: no capture, no halt, and `cycle_count` unchanged.

Source files
------------

// File: rtl/arm_trace_pkg.sv
// -----------------------------------------------------------------------------
// arm_trace_pkg
// Shared types and constants for the ARM execution-trace capture block.
//   HALT_INSTR_DEFAULT : instruction word that ends capture unless overridden
//   trace_state_t      : capture controller states
//   trace_entry_t      : one captured sample, 98 bits
//                        {instr[31:0], pc[31:0], alu[31:0], aluctl[1:0]}
// -----------------------------------------------------------------------------
package arm_trace_pkg;

    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hE000_0000;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2
    } trace_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [1:0]  aluctl;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Synchronous show-ahead FIFO of trace_entry_t, DEPTH entries (power of two).
// The head entry is driven combinationally from storage and the read pointer,
// so dout is valid in the same cycle that empty is low.
// A push while full is accepted when a pop happens on the same edge, since
// the pop frees the slot the push needs.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (pointers/count only)
//   push, din  : write request and data
//   pop        : read request (ignored when empty)
//   dout       : head entry, don't-care while empty
//   empty      : no entries held
//   count      : occupancy, 0..DEPTH
//   push_ok    : the write request is accepted on this edge
//   pop_ok     : a pop happens on this edge
// -----------------------------------------------------------------------------
module trace_fifo
    import arm_trace_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  trace_entry_t din,
    input  logic         pop,
    output trace_entry_t dout,
    output logic         empty,
    output logic [AW:0]  count,
    output logic         push_ok,
    output logic         pop_ok
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    trace_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            full;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; stale contents are unreachable after reset
    // because the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/arm_trace_capture.sv
// -----------------------------------------------------------------------------
// arm_trace_capture
// Samples the single-cycle ARM core's debug outputs into a circular trace
// buffer every enabled cycle, stops capturing on the halt instruction, and
// lets a consumer drain the ordered trace through a valid/ready port.
// Ports:
//   CLK, RST              : clock, synchronous active-high reset
//   Instr, PC_out,
//   ALUResult, ALUControl : core outputs for the current cycle
//   cap_en                : core outputs are valid this cycle
//   rd_valid, rd_ready    : read handshake for the head entry
//   rd_instr, rd_pc,
//   rd_alu, rd_aluctl     : head entry fields (show-ahead)
//   halted                : halt instruction has been seen
//   done                  : halted and buffer fully drained
//   overflow              : sticky, at least one sample dropped
//   drop_count            : dropped samples, saturating
//   cycle_count           : enabled capture cycles incl. halt, saturating
// -----------------------------------------------------------------------------
module arm_trace_capture
    import arm_trace_pkg::*;
#(
    parameter int          DEPTH      = 16,
    parameter int          CNT_W      = 16,
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      Instr,
    input  logic [31:0]      PC_out,
    input  logic [31:0]      ALUResult,
    input  logic [1:0]       ALUControl,
    input  logic             cap_en,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [31:0]      rd_instr,
    output logic [31:0]      rd_pc,
    output logic [31:0]      rd_alu,
    output logic [1:0]       rd_aluctl,
    output logic             halted,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int AW = $clog2(DEPTH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    trace_state_t  state_q;
    trace_state_t  state_d;

    trace_entry_t  wr_entry;
    trace_entry_t  head;
    logic          fifo_empty;
    logic [AW:0]   occupancy;
    logic          push_ok;
    logic          pop_ok;

    logic          capturing;
    logic          is_halt;
    logic          wr_req;
    logic          pop_req;
    logic          drop;
    logic          drain_empty_next;

    assign capturing = (state_q == CAPTURE);
    assign is_halt   = (Instr == HALT_INSTR);
    // The halt word itself is never stored.
    assign wr_req    = capturing && cap_en && !is_halt;
    assign pop_req   = rd_valid && rd_ready;
    // A write that the FIFO refused is a drop of the newest sample.
    assign drop      = wr_req && !push_ok;

    assign wr_entry.instr  = Instr;
    assign wr_entry.pc     = PC_out;
    assign wr_entry.alu    = ALUResult;
    assign wr_entry.aluctl = ALUControl;

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push    (wr_req),
        .din     (wr_entry),
        .pop     (pop_req),
        .dout    (head),
        .empty   (fifo_empty),
        .count   (occupancy),
        .push_ok (push_ok),
        .pop_ok  (pop_ok)
    );

    assign rd_valid  = !fifo_empty;
    assign rd_instr  = head.instr;
    assign rd_pc     = head.pc;
    assign rd_alu    = head.alu;
    assign rd_aluctl = head.aluctl;

    // No pushes happen outside CAPTURE, so post-edge occupancy in DRAIN is
    // zero when already empty or when the last entry pops on this edge.
    assign drain_empty_next = (occupancy == '0) ||
                              ((occupancy == (AW+1)'(1)) && pop_ok);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= CAPTURE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        halted  = 1'b1;
        done    = 1'b0;
        case (state_q)
            CAPTURE: begin
                halted = 1'b0;
                if (cap_en && is_halt) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_empty_next) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                state_d = CAPTURE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            overflow    <= 1'b0;
            drop_count  <= '0;
            cycle_count <= '0;
        end else begin
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= sat_inc(drop_count);
            end
            if (capturing && cap_en) begin
                cycle_count <= sat_inc(cycle_count);
            end
        end
    end

endmodule

// File: tb/tb_arm_trace_capture.sv
// -----------------------------------------------------------------------------
// tb_arm_trace_capture
// Scoreboard bench: the stimulus side predicts the buffer contents from the
// capture rules (an ordered queue plus a few counters) and the monitor checks
// every handshake and status output on the falling edge.
// -----------------------------------------------------------------------------
module tb_arm_trace_capture;

    localparam int          DEPTH  = 16;
    localparam int          CNT_W  = 16;
    localparam logic [31:0] HALT_I = 32'hE000_0000;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [31:0]      Instr = '0;
    logic [31:0]      PC_out = '0;
    logic [31:0]      ALUResult = '0;
    logic [1:0]       ALUControl = '0;
    logic             cap_en = 1'b0;
    logic             rd_valid;
    logic             rd_ready = 1'b0;
    logic [31:0]      rd_instr;
    logic [31:0]      rd_pc;
    logic [31:0]      rd_alu;
    logic [1:0]       rd_aluctl;
    logic             halted;
    logic             done;
    logic             overflow;
    logic [CNT_W-1:0] drop_count;
    logic [CNT_W-1:0] cycle_count;

    arm_trace_capture #(
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W),
        .HALT_INSTR (HALT_I)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Instr       (Instr),
        .PC_out      (PC_out),
        .ALUResult   (ALUResult),
        .ALUControl  (ALUControl),
        .cap_en      (cap_en),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_instr    (rd_instr),
        .rd_pc       (rd_pc),
        .rd_alu      (rd_alu),
        .rd_aluctl   (rd_aluctl),
        .halted      (halted),
        .done        (done),
        .overflow    (overflow),
        .drop_count  (drop_count),
        .cycle_count (cycle_count)
    );

    always #5 CLK = ~CLK;

    // Reference model: 0 = capturing, 1 = draining, 2 = done.
    logic [97:0]  sb [$];
    int           m_state = 0;
    bit           m_ovf   = 1'b0;
    int           m_drop  = 0;
    int           m_cycle = 0;
    bit           mon_on  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model is advanced by the capture rules.
    task automatic step(input bit en, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [1:0] ctl, input bit rdy);
        int occ;
        bit pop;
        bit wr;
        cap_en     = en;
        Instr      = ins;
        PC_out     = pc;
        ALUResult  = alu;
        ALUControl = ctl;
        rd_ready   = rdy;
        occ = sb.size();
        pop = (occ > 0) && rdy;
        wr  = (m_state == 0) && en && (ins != HALT_I);
        @(posedge CLK);
        if (wr) begin
            if (occ < DEPTH || pop) begin
                sb.push_back({ins, pc, alu, ctl});
            end else begin
                m_ovf = 1'b1;
                if (m_drop < (1 << CNT_W) - 1) m_drop++;
            end
        end
        if (m_state == 0 && en) begin
            if (m_cycle < (1 << CNT_W) - 1) m_cycle++;
            if (ins == HALT_I) m_state = 1;
        end else if (m_state == 1 && (occ - (pop ? 1 : 0)) == 0) begin
            m_state = 2;
        end
        #1;
    endtask

    task automatic rnd_step(input bit en, input bit rdy);
        logic [31:0] ins;
        ins = $urandom;
        if (ins == HALT_I) ins = 32'h0;
        step(en, ins, $urandom, $urandom, 2'($urandom), rdy);
    endtask

    task automatic do_reset();
        RST      = 1'b1;
        cap_en   = 1'b0;
        rd_ready = 1'b0;
        @(posedge CLK);
        sb.delete();
        m_state = 0;
        m_ovf   = 1'b0;
        m_drop  = 0;
        m_cycle = 0;
        #1;
        RST = 1'b0;
    endtask

    // Drain after halt; optionally keep feeding words (incl. halt) that must be ignored.
    task automatic drain(input int pct, input bit feed, input string tag);
        int budget;
        int prev;
        logic [31:0] ins;
        budget = 300;
        while (m_state != 2 && budget > 0) begin
            prev = sb.size();
            ins  = ($urandom_range(0, 3) == 0) ? HALT_I : $urandom;
            step(feed, ins, $urandom, $urandom, 2'($urandom), $urandom_range(0, 99) < pct);
            if (prev > 0 && sb.size() == 0) check({tag, "_done_after_last_pop"}, done, 1);
            budget--;
        end
        check({tag, "_drain_done"}, done, 1);
    endtask

    // Monitor: compares every handshake against the scoreboard and the status outputs.
    always @(negedge CLK) begin
        if (mon_on) begin
            check("rd_valid", rd_valid, sb.size() != 0);
            if (rd_valid && rd_ready && sb.size() != 0) begin
                logic [97:0] exp;
                exp = sb.pop_front();
                check("entry", {rd_instr, rd_pc, rd_alu, rd_aluctl}, exp);
            end
            check("halted", halted, m_state != 0);
            check("done", done, m_state == 2);
            check("overflow", overflow, m_ovf);
            check("drop_count", drop_count, m_drop);
            check("cycle_count", cycle_count, m_cycle);
        end
    end

    initial begin
        do_reset();
        do_reset();
        mon_on = 1'b1;
        check("rst_rd_valid", rd_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_cycle_count", cycle_count, 0);

        // Basic capture and halt, no reads.
        for (int i = 0; i < 3; i++)
            step(1, 32'hE280_1000 + i, 32'(i * 4), 32'h100 + i, 2'(i), 0);
        step(1, HALT_I, 32'hC, 32'h0, 2'd0, 0);
        check("t1_halted", halted, 1);
        check("t1_cycle_count", cycle_count, 4);
        check("t1_rd_pc_head", rd_pc, 0);
        // Drain while feeding further words, halt included.
        drain(50, 1, "t4");
        for (int i = 0; i < 4; i++) rnd_step(1, 1);
        check("t4_no_capture_after_done", rd_valid, 0);

        // Overflow: 20 samples into 16 slots, no reads.
        do_reset();
        for (int i = 0; i < 20; i++)
            step(1, 32'hA000_0000 + i, 32'(i * 4), $urandom, 2'($urandom), 0);
        check("t2_overflow", overflow, 1);
        check("t2_drop_count", drop_count, 4);
        // Full with simultaneous pop and push.
        step(1, 32'hB000_0001, 32'h1000, 32'h55, 2'd3, 1);
        check("t3_drop_count", drop_count, 4);
        check("t3_rd_pc_second", rd_pc, 4);
        step(1, HALT_I, 32'h1004, 32'h0, 2'd0, 0);
        drain(60, 0, "t3");

        // Reset mid-drain with 5 entries held.
        do_reset();
        for (int i = 0; i < 5; i++) rnd_step(1, 0);
        step(1, HALT_I, 32'h0, 32'h0, 2'd0, 0);
        rnd_step(0, 0);
        check("t5_pre_halted", halted, 1);
        do_reset();
        check("t5_rd_valid", rd_valid, 0);
        check("t5_halted", halted, 0);
        check("t5_done", done, 0);
        check("t5_overflow", overflow, 0);
        check("t5_drop_count", drop_count, 0);
        check("t5_cycle_count", cycle_count, 0);

        // Enable gating: nothing happens with cap_en low, even for halt.
        for (int i = 0; i < 6; i++)
            step(0, (i % 2 == 0) ? HALT_I : $urandom, $urandom, $urandom, 2'($urandom), 1);
        check("t6_halted", halted, 0);
        check("t6_cycle_count", cycle_count, 0);
        check("t6_rd_valid", rd_valid, 0);
        for (int i = 0; i < 3; i++) rnd_step(1, 0);
        check("t5_capture_restarts", rd_valid, 1);
        step(1, HALT_I, 32'h0, 32'h0, 2'd0, 0);
        drain(40, 1, "t5");

        // Randomized run with varying read pressure and occasional halts/resets.
        do_reset();
        for (int blk = 0; blk < 8; blk++) begin
            int pct;
            pct = $urandom_range(0, 100);
            for (int i = 0; i < 200; i++) begin
                bit en;
                bit rdy;
                en  = $urandom_range(0, 3) != 0;
                rdy = $urandom_range(0, 99) < pct;
                if ($urandom_range(0, 79) == 0)
                    step(en, HALT_I, $urandom, $urandom, 2'($urandom), rdy);
                else
                    rnd_step(en, rdy);
                if (m_state == 2 && $urandom_range(0, 7) == 0) do_reset();
            end
        end

        @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
